// File: rtl/relu_maxpool_stage.sv
// relu_maxpool_stage: ReLU followed by 2x2 stride-2 max pooling over a raster
// stream of convolution outputs. All features are processed in parallel.
// Ports:
//   clk            rising-edge clock
//   rst_pool       asynchronous active-low reset
//   in_valid       input beat valid (no backpressure)
//   in_data        NUM_FEATURES signed samples, feature f at [f*DATA_WIDTH +: DATA_WIDTH]
//   frame_restart  synchronous pulse, return to start of frame (wins over in_valid)
//   out_valid      one-cycle pulse per completed pooling window
//   out_data       pooled samples (non-negative), same packing as in_data
//   out_row/out_col pooled window index of out_data
//   frame_done     high after the last beat of the frame until restart/reset
module relu_maxpool_stage #(
  parameter int unsigned NUM_FEATURES = 10,
  parameter int unsigned IN_WIDTH     = 30,
  parameter int unsigned IN_HEIGHT    = 30,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_pool,
  input  logic                                 in_valid,
  input  logic [NUM_FEATURES*DATA_WIDTH-1:0]   in_data,
  input  logic                                 frame_restart,
  output logic                                 out_valid,
  output logic [NUM_FEATURES*DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(IN_HEIGHT/2):0]         out_row,
  output logic [$clog2(IN_WIDTH/2):0]          out_col,
  output logic                                 frame_done
);

  localparam int unsigned BUS_W    = NUM_FEATURES * DATA_WIDTH;
  localparam int unsigned RCW      = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned CCW      = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned OROW_W   = $clog2(IN_HEIGHT/2) + 1;
  localparam int unsigned OCOL_W   = $clog2(IN_WIDTH/2) + 1;
  localparam int unsigned NUM_HALF = (IN_WIDTH / 2 > 0) ? IN_WIDTH / 2 : 1;
  localparam int unsigned LB_AW    = (NUM_HALF > 1) ? $clog2(NUM_HALF) : 1;
  localparam bit          ODD_W    = (IN_WIDTH % 2) != 0;
  localparam bit          ODD_H    = (IN_HEIGHT % 2) != 0;
  localparam logic [RCW-1:0] LAST_ROW = RCW'(IN_HEIGHT - 1);
  localparam logic [CCW-1:0] LAST_COL = CCW'(IN_WIDTH - 1);

  typedef enum logic {S_ACTIVE, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_in_window;
  logic [LB_AW-1:0]     w_lb_idx;
  logic [RCW-1:0]       r_in_row;
  logic [CCW-1:0]       r_in_col;
  logic [BUS_W-1:0]     r_pair;
  logic [BUS_W-1:0]     r_linebuf [NUM_HALF];
  logic [BUS_W-1:0]     w_relu;
  logic [BUS_W-1:0]     w_max_pair;
  logic [BUS_W-1:0]     w_max_lb;
  logic                 r_out_valid;
  logic [BUS_W-1:0]     r_out_data;
  logic [OROW_W-1:0]    r_out_row;
  logic [OCOL_W-1:0]    r_out_col;
  logic                 r_frame_done;

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? '0 : x;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign w_last   = (r_in_row == LAST_ROW) && (r_in_col == LAST_COL);
  assign w_lb_idx = LB_AW'(r_in_col >> 1);
  // Trailing row/column of an odd dimension never belongs to a window.
  assign w_in_window = !(ODD_H && (r_in_row == LAST_ROW)) &&
                       !(ODD_W && (r_in_col == LAST_COL));

  // Per-feature ReLU and the two candidate maxima.
  always_comb begin
    w_relu     = '0;
    w_max_pair = '0;
    w_max_lb   = '0;
    for (int unsigned f = 0; f < NUM_FEATURES; f++) begin
      w_relu[f*DATA_WIDTH +: DATA_WIDTH]     = relu(in_data[f*DATA_WIDTH +: DATA_WIDTH]);
      w_max_pair[f*DATA_WIDTH +: DATA_WIDTH] = smax(r_pair[f*DATA_WIDTH +: DATA_WIDTH],
                                                    w_relu[f*DATA_WIDTH +: DATA_WIDTH]);
      w_max_lb[f*DATA_WIDTH +: DATA_WIDTH]   = smax(r_linebuf[w_lb_idx][f*DATA_WIDTH +: DATA_WIDTH],
                                                    w_relu[f*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_pool) begin
    if (!rst_pool) r_state <= S_ACTIVE;
    else           r_state <= w_state_nxt;
  end

  // Next state and beat acceptance; restart overrides any beat.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (frame_restart) begin
      w_state_nxt = S_ACTIVE;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          if (in_valid) begin
            w_accept = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_DONE;
        default: w_state_nxt = S_ACTIVE;
      endcase
    end
  end

  // Counters, pooling storage and registered outputs.
  always_ff @(posedge clk or negedge rst_pool) begin
    if (!rst_pool) begin
      r_in_row     <= '0;
      r_in_col     <= '0;
      r_pair       <= '0;
      for (int unsigned i = 0; i < NUM_HALF; i++) r_linebuf[i] <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (frame_restart) begin
        r_in_row     <= '0;
        r_in_col     <= '0;
        r_frame_done <= 1'b0;
      end else if (w_accept) begin
        if (r_in_col == LAST_COL) begin
          r_in_col <= '0;
          r_in_row <= r_in_row + 1'b1;
        end else begin
          r_in_col <= r_in_col + 1'b1;
        end
        if (w_in_window) begin
          // Low bits of row/col select the role of this beat inside its window.
          case ({r_in_row[0], r_in_col[0]})
            2'b00: r_pair <= w_relu;
            2'b01: r_linebuf[w_lb_idx] <= w_max_pair;
            2'b10: r_pair <= w_max_lb;
            2'b11: begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_max_pair;
              r_out_row   <= OROW_W'(r_in_row >> 1);
              r_out_col   <= OCOL_W'(r_in_col >> 1);
            end
            default: r_pair <= r_pair;
          endcase
        end
        if (w_last) r_frame_done <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Bench for relu_maxpool_stage: three instances (4x4, 2x2, 5x5; two features)
// driven one at a time, checked cycle by cycle against a frame-array model.
module tb_relu_maxpool_stage;

  localparam int unsigned NF = 2;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_pool;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          frame_restart;
  int            sel;

  logic          a_ov, b_ov, c_ov, a_fd, b_fd, c_fd;
  logic [15:0]   a_od, b_od, c_od;
  logic [1:0]    a_or, a_oc, c_or, c_oc;
  logic [0:0]    b_or, b_oc;

  logic          ov, fd;
  logic [15:0]   od;
  int            orow, ocol;

  int            n_checks;
  int            n_fail;
  int            cur_w, cur_h;
  bit            exp_done;
  int            fr [NF][5][5];

  relu_maxpool_stage #(.NUM_FEATURES(NF), .IN_WIDTH(4), .IN_HEIGHT(4), .DATA_WIDTH(DW)) u_a (
    .clk(clk), .rst_pool(rst_pool), .in_valid(in_valid && sel == 0), .in_data(in_data),
    .frame_restart(frame_restart && sel == 0), .out_valid(a_ov), .out_data(a_od),
    .out_row(a_or), .out_col(a_oc), .frame_done(a_fd));

  relu_maxpool_stage #(.NUM_FEATURES(NF), .IN_WIDTH(2), .IN_HEIGHT(2), .DATA_WIDTH(DW)) u_b (
    .clk(clk), .rst_pool(rst_pool), .in_valid(in_valid && sel == 1), .in_data(in_data),
    .frame_restart(frame_restart && sel == 1), .out_valid(b_ov), .out_data(b_od),
    .out_row(b_or), .out_col(b_oc), .frame_done(b_fd));

  relu_maxpool_stage #(.NUM_FEATURES(NF), .IN_WIDTH(5), .IN_HEIGHT(5), .DATA_WIDTH(DW)) u_c (
    .clk(clk), .rst_pool(rst_pool), .in_valid(in_valid && sel == 2), .in_data(in_data),
    .frame_restart(frame_restart && sel == 2), .out_valid(c_ov), .out_data(c_od),
    .out_row(c_or), .out_col(c_oc), .frame_done(c_fd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance to common observation signals.
  always_comb begin
    ov = 1'b0; fd = 1'b0; od = '0; orow = 0; ocol = 0;
    case (sel)
      0: begin ov = a_ov; fd = a_fd; od = a_od; orow = int'(a_or); ocol = int'(a_oc); end
      1: begin ov = b_ov; fd = b_fd; od = b_od; orow = int'(b_or); ocol = int'(b_oc); end
      default: begin ov = c_ov; fd = c_fd; od = c_od; orow = int'(c_or); ocol = int'(c_oc); end
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d, t=%0t): got %0d expected %0d", tag, sel, $time, got, exp);
    end
  endtask

  function automatic int relu_m(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int feat_out(input int f);
    return int'($signed(od[f*DW +: DW]));
  endfunction

  // Pooled value of the window whose bottom-right beat is (r,c).
  function automatic int window_max(input int f, input int r, input int c);
    int m;
    m = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (relu_m(fr[f][r-dr][c-dc]) > m) m = relu_m(fr[f][r-dr][c-dc]);
    return m;
  endfunction

  task automatic select_inst(input int s);
    sel = s;
    cur_w = (s == 0) ? 4 : (s == 1) ? 2 : 5;
    cur_h = cur_w;
    exp_done = 1'b0;
    #1;
  endtask

  task automatic load_ramp();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        fr[0][r][c] = r * cur_w + c;
        fr[1][r][c] = -(r * cur_w + c);
      end
  endtask

  task automatic load_random();
    for (int f = 0; f < int'(NF); f++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          fr[f][r][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic drive_data(input int r, input int c);
    for (int f = 0; f < int'(NF); f++) in_data[f*DW +: DW] = 8'(fr[f][r][c]);
  endtask

  // One clock: present (optionally valid) beat (r,c), then check the outputs it causes.
  task automatic step(input bit valid, input int r, input int c);
    bit exp_v;
    in_valid = valid;
    drive_data(r, c);
    @(posedge clk);
    #1;
    exp_v = valid && !exp_done && (r % 2 == 1) && (c % 2 == 1) &&
            (r < 2 * (cur_h / 2)) && (c < 2 * (cur_w / 2));
    if (valid && !exp_done && r == cur_h - 1 && c == cur_w - 1) exp_done = 1'b1;
    check("out_valid", int'(ov), int'(exp_v));
    check("frame_done", int'(fd), int'(exp_done));
    if (exp_v) begin
      for (int f = 0; f < int'(NF); f++) check("out_data", feat_out(f), window_max(f, r, c));
      check("out_row", orow, r / 2);
      check("out_col", ocol, c / 2);
    end
    in_valid = 1'b0;
  endtask

  // mode 0: continuous, 1: valid pattern 1,0,0,1, 2: random gaps.
  task automatic send_frame(input int mode);
    int cyc;
    cyc = 0;
    for (int r = 0; r < cur_h; r++)
      for (int c = 0; c < cur_w; c++) begin
        if (mode == 1) begin
          while (!((cyc % 4 == 0) || (cyc % 4 == 3))) begin step(1'b0, r, c); cyc++; end
        end else if (mode == 2) begin
          while ($urandom_range(0, 2) == 0) step(1'b0, r, c);
        end
        step(1'b1, r, c);
        cyc++;
      end
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) step(1'b1, i / cur_w, i % cur_w);
  endtask

  task automatic restart_pulse();
    frame_restart = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    frame_restart = 1'b0;
    exp_done = 1'b0;
    check("restart_valid", int'(ov), 0);
    check("restart_done", int'(fd), 0);
  endtask

  // Restart together with a valid beat at (r,c): the beat must vanish.
  task automatic collision(input int r, input int c);
    frame_restart = 1'b1;
    in_valid = 1'b1;
    drive_data(r, c);
    @(posedge clk);
    #1;
    frame_restart = 1'b0;
    in_valid = 1'b0;
    exp_done = 1'b0;
    check("collide_valid", int'(ov), 0);
    check("collide_done", int'(fd), 0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    in_valid = 1'b0; in_data = '0; frame_restart = 1'b0;
    rst_pool = 1'b0;
    select_inst(0);
    repeat (2) @(posedge clk);
    #3;
    for (int s = 0; s < 3; s++) begin
      select_inst(s);
      check("rst_valid", int'(ov), 0);
      check("rst_data", int'(od), 0);
      check("rst_row", orow, 0);
      check("rst_col", ocol, 0);
      check("rst_done", int'(fd), 0);
    end
    rst_pool = 1'b1;

    // Ramp frame, continuous, then ignored beats while done.
    select_inst(0);
    load_ramp();
    send_frame(0);
    send_beats(3);
    restart_pulse();

    // Same ramp with bubbles.
    send_frame(1);
    restart_pulse();

    // ReLU / sign on a single 2x2 window.
    select_inst(1);
    fr[0][0][0] = -128; fr[0][0][1] = -1; fr[0][1][0] = -5; fr[0][1][1] = 3;
    fr[1][0][0] = -1; fr[1][0][1] = -128; fr[1][1][0] = -7; fr[1][1][1] = -2;
    send_frame(0);
    restart_pulse();
    fr[0][0][0] = -128; fr[0][0][1] = -1; fr[0][1][0] = -5; fr[0][1][1] = -3;
    fr[1][0][0] = 9; fr[1][0][1] = 127; fr[1][1][0] = 0; fr[1][1][1] = 100;
    send_frame(0);

    // Odd dimensions, extra beats after done, async reset clears frame_done.
    select_inst(2);
    load_ramp();
    send_frame(0);
    send_beats(4);
    #1 rst_pool = 1'b0;
    #1;
    check("async_rst_done", int'(fd), 0);
    check("async_rst_data", int'(od), 0);
    #2 rst_pool = 1'b1;
    exp_done = 1'b0;
    load_random();
    send_frame(2);

    // Restart colliding with a beat, then full frames.
    select_inst(0);
    load_ramp();
    restart_pulse();
    send_beats(6);
    collision(1, 2);
    send_frame(0);
    restart_pulse();
    send_beats(5);
    collision(1, 1);
    load_random();
    send_frame(2);
    restart_pulse();

    // Async reset right after a pulse, mid-frame.
    load_ramp();
    send_beats(6);
    #1 rst_pool = 1'b0;
    #1;
    check("async_rst_valid", int'(ov), 0);
    check("async_rst_done", int'(fd), 0);
    check("async_rst_data", int'(od), 0);
    #2 rst_pool = 1'b1;
    exp_done = 1'b0;
    send_frame(0);

    // Random frames with random gaps on both odd and even instances.
    for (int k = 0; k < 4; k++) begin
      select_inst(k % 2 == 0 ? 0 : 2);
      restart_pulse();
      load_random();
      send_frame(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
